// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data RAM arbiter between the MEM stage and the key/message loader
module dmem_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int WAIT_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic              cpu_stall,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic              ld_lock,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_gnt,
   output logic [DATA_W-1:0] ld_rdata,
   output logic              ld_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {S_NORM = 1'b0, S_LOCK = 1'b1} state_t;

   localparam logic [3:0] WAIT_MAX_C = 4'(WAIT_MAX);

   state_t      state_q, state_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;
   logic        cpu_rvalid_q, ld_rvalid_q;
   logic        gnt_cpu, gnt_ld, force_ld;

   // CPU wins in normal mode unless the loader has waited WAIT_MAX cycles
   always_comb begin
      force_ld = 1'b0;
      gnt_cpu  = 1'b0;
      gnt_ld   = 1'b0;
      if (state_q == S_NORM) begin
         force_ld = ld_req & (starve_cnt_q == WAIT_MAX_C);
         gnt_cpu  = cpu_req & ~force_ld;
         gnt_ld   = ld_req & ~gnt_cpu;
      end else begin
         gnt_ld   = ld_req;
      end
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (~ld_req | gnt_ld)
         starve_cnt_d = 4'd0;
      else if (starve_cnt_q < WAIT_MAX_C)
         starve_cnt_d = starve_cnt_q + 4'd1;

      state_d = state_q;
      case (state_q)
         S_NORM: if (gnt_ld & ld_lock) state_d = S_LOCK;
         S_LOCK: if (~ld_lock)         state_d = S_NORM;
         default:                      state_d = S_NORM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_NORM;
         starve_cnt_q <= 4'd0;
         cpu_rvalid_q <= 1'b0;
         ld_rvalid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         cpu_rvalid_q <= gnt_cpu & ~cpu_we;
         ld_rvalid_q  <= gnt_ld & ~ld_we;
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt_cpu) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (gnt_ld) begin
         mem_we    = ld_we;
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
      end
   end

   assign mem_en     = gnt_cpu | gnt_ld;
   assign ld_gnt     = gnt_ld;
   assign cpu_stall  = cpu_req & ~gnt_cpu;
   assign cpu_rvalid = cpu_rvalid_q;
   assign ld_rvalid  = ld_rvalid_q;
   assign cpu_rdata  = mem_rdata;
   assign ld_rdata   = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural RAM
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, cpu_rvalid, cpu_stall;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        ld_req, ld_we, ld_lock, ld_gnt, ld_rvalid;
   logic [31:0] ld_addr, ld_wdata, ld_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
      .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
      .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Word-addressed RAM with one-cycle read latency; preload reapplied on rst
   logic [31:0] ram [0:63];
   always @(posedge clk) begin
      if (rst) begin
         ram[1] <= 32'h1111_1111;
         ram[2] <= 32'h2222_2222;
         ram[4] <= 32'hDEAD_BEEF;
      end
      if (mem_en) begin
         if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr[7:2]];
      end
   end

   typedef struct {
      logic        rst, cq, cwe;
      logic [31:0] ca, cd;
      logic        lq, lwe, llk;
      logic [31:0] la, ld;
      logic        egc, egl;
      logic [31:0] erd;
      logic        chk;
   } vec_t;

   typedef struct {
      logic        gnt, stall, en, we;
      logic [31:0] addr, wdata;
      logic        crv, lrv, chk;
   } exp_t;

   vec_t        vecs[$];
   exp_t        exp_q[$];
   logic [31:0] cpu_rd_q[$];
   logic [31:0] ld_rd_q[$];
   int          n_cmp = 0;
   int          n_mis = 0;
   bit          done = 1'b0;

   task automatic v(input logic r, cq, cwe, input logic [31:0] ca, cd,
                    input logic lq, lwe, llk, input logic [31:0] la, ld,
                    input logic egc, egl, input logic [31:0] erd, input logic chk);
      vec_t t;
      t.rst = r; t.cq = cq; t.cwe = cwe; t.ca = ca; t.cd = cd;
      t.lq = lq; t.lwe = lwe; t.llk = llk; t.la = la; t.ld = ld;
      t.egc = egc; t.egl = egl; t.erd = erd; t.chk = chk;
      vecs.push_back(t);
   endtask

   task automatic idle();
      v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor: compares the per-cycle expectation and pops read data on each rvalid
   initial begin
      exp_t e;
      while (!done) begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
               cmp("ld_gnt",     {31'd0, ld_gnt},     {31'd0, e.gnt});
               cmp("cpu_stall",  {31'd0, cpu_stall},  {31'd0, e.stall});
               cmp("mem_en",     {31'd0, mem_en},     {31'd0, e.en});
               cmp("mem_we",     {31'd0, mem_we},     {31'd0, e.we});
               cmp("mem_addr",   mem_addr,            e.addr);
               cmp("mem_wdata",  mem_wdata,           e.wdata);
               cmp("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, e.crv});
               cmp("ld_rvalid",  {31'd0, ld_rvalid},  {31'd0, e.lrv});
            end
         end
         if (cpu_rvalid === 1'b1) begin
            if (cpu_rd_q.size() == 0) cmp("cpu_rvalid_unexpected", 32'd1, 32'd0);
            else cmp("cpu_rdata", cpu_rdata, cpu_rd_q.pop_front());
         end
         if (ld_rvalid === 1'b1) begin
            if (ld_rd_q.size() == 0) cmp("ld_rvalid_unexpected", 32'd1, 32'd0);
            else cmp("ld_rdata", ld_rdata, ld_rd_q.pop_front());
         end
      end
   end

   initial begin
      exp_t e;
      logic prev_crd, prev_lrd;
      rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      ld_req = 0; ld_we = 0; ld_lock = 0; ld_addr = 0; ld_wdata = 0;

      v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle();
      v(0, 1, 0, 'h10, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 1);
      idle();
      // Continuous contention: four CPU grants then one forced loader grant
      for (int i = 0; i < 10; i++) begin
         if (i % 5 == 4) v(0, 1, 0, 'h04, 0, 1, 0, 0, 'h08, 0, 0, 1, 32'h22222222, 1);
         else            v(0, 1, 0, 'h04, 0, 1, 0, 0, 'h08, 0, 1, 0, 32'h11111111, 1);
      end
      idle();
      v(0, 0, 0, 0,     0, 1, 1, 1, 'h40, 'h1234, 0, 1, 0, 1);
      v(0, 1, 0, 'h04,  0, 1, 1, 1, 'h44, 'h5555, 0, 1, 0, 1);
      v(0, 1, 0, 'h04,  0, 1, 1, 1, 'h48, 'h6666, 0, 1, 0, 1);
      v(0, 1, 0, 'h04,  0, 1, 1, 0, 'h4C, 'h7777, 0, 1, 0, 1);
      v(0, 1, 0, 'h40,  0, 0, 0, 0, 0,    0,      1, 0, 32'h1234, 1);
      idle();
      // Reset while locked: the read issued in the reset cycle must not return
      v(0, 0, 0, 0,     0, 1, 0, 1, 'h40, 0, 0, 1, 32'h1234, 1);
      v(1, 1, 0, 'h04,  0, 1, 0, 1, 'h44, 0, 0, 1, 0, 1);
      v(0, 1, 0, 'h04,  0, 1, 0, 1, 'h44, 0, 1, 0, 32'h11111111, 1);
      idle();
      v(0, 1, 1, 'h20, 32'hA5A5A5A5, 1, 0, 0, 'h20, 0, 1, 0, 0, 1);
      v(0, 0, 0, 0,    0,            1, 0, 0, 'h20, 0, 0, 1, 32'hA5A5A5A5, 1);
      idle();
      idle();

      prev_crd = 1'b0;
      prev_lrd = 1'b0;
      foreach (vecs[n]) begin
         @(posedge clk);
         #1;
         rst = vecs[n].rst; cpu_req = vecs[n].cq; cpu_we = vecs[n].cwe;
         cpu_addr = vecs[n].ca; cpu_wdata = vecs[n].cd;
         ld_req = vecs[n].lq; ld_we = vecs[n].lwe; ld_lock = vecs[n].llk;
         ld_addr = vecs[n].la; ld_wdata = vecs[n].ld;
         e.gnt   = vecs[n].egl;
         e.stall = vecs[n].cq & ~vecs[n].egc;
         e.en    = vecs[n].egc | vecs[n].egl;
         e.we    = vecs[n].egc ? vecs[n].cwe : (vecs[n].egl ? vecs[n].lwe : 1'b0);
         e.addr  = vecs[n].egc ? vecs[n].ca  : (vecs[n].egl ? vecs[n].la  : 32'd0);
         e.wdata = vecs[n].egc ? vecs[n].cd  : (vecs[n].egl ? vecs[n].ld  : 32'd0);
         e.crv   = prev_crd;
         e.lrv   = prev_lrd;
         e.chk   = vecs[n].chk;
         exp_q.push_back(e);
         prev_crd = vecs[n].egc & ~vecs[n].cwe & ~vecs[n].rst;
         prev_lrd = vecs[n].egl & ~vecs[n].lwe & ~vecs[n].rst;
         if (prev_crd) cpu_rd_q.push_back(vecs[n].erd);
         if (prev_lrd) ld_rd_q.push_back(vecs[n].erd);
      end
      @(posedge clk);
      @(negedge clk);
      #2;
      done = 1'b1;
      cmp("exp_q_drained",    exp_q.size(),    32'd0);
      cmp("cpu_rd_q_drained", cpu_rd_q.size(), 32'd0);
      cmp("ld_rd_q_drained",  ld_rd_q.size(),  32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between the pipeline MEM stage and the external key/message loader port.
- The CPU has priority. An anti-starvation counter guarantees the loader a slot. A lock mode gives the loader exclusive ownership while it streams keys or operands.
- Sits between the MEM stage and the data RAM. Drives cpu_stall into the hazard unit so the pipeline freezes while the CPU is denied.

Parameters:
- DATA_W, 32, data width of both requesters and the RAM.
- ADDR_W, 32, address width.
- WAIT_MAX, 4, consecutive denied loader cycles before the loader is forced a grant (legal range 1..15).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  MEM-stage access request (MemWrite or load in MEM).
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  MEM-stage address.
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data.
- cpu_rvalid  out  1  cpu_rdata valid this cycle.
- cpu_stall  out  1  CPU request pending but not granted.
- ld_req  in  1  loader request.
- ld_we  in  1  loader write enable.
- ld_lock  in  1  loader requests exclusive ownership.
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- ld_gnt  out  1  loader access accepted this cycle.
- ld_rdata  out  DATA_W  loader read data.
- ld_rvalid  out  1  ld_rdata valid this cycle.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency after mem_en.

Behaviour:
- States: S_NORM, S_LOCK. Reset puts the block in S_NORM with starve_cnt = 0, cpu_rvalid = 0 and ld_rvalid = 0.
- Grant logic is combinational from the current state and inputs:
  - S_NORM: force = ld_req & (starve_cnt == WAIT_MAX). gnt_cpu = cpu_req & ~force. gnt_ld = ld_req & ~gnt_cpu.
  - S_LOCK: gnt_cpu = 0. gnt_ld = ld_req.
- Outputs derived from the grants:
  - ld_gnt = gnt_ld.
  - cpu_stall = cpu_req & ~gnt_cpu.
  - mem_en = gnt_cpu | gnt_ld.
  - mem_we, mem_addr and mem_wdata are muxed from the granted requester. With no grant they are all 0.
- starve_cnt:
  - Clears when ~ld_req or gnt_ld.
  - Otherwise increments, saturating at WAIT_MAX.
  - Width is 4 bits.
- Transitions:
  - S_NORM -> S_LOCK when gnt_ld & ld_lock.
  - S_LOCK -> S_NORM when ~ld_lock. The loader may still be granted in that last S_LOCK cycle; the CPU is eligible from the next cycle.
- Read return:
  - cpu_rvalid <= gnt_cpu & ~cpu_we.
  - ld_rvalid <= gnt_ld & ~ld_we.
  - cpu_rdata = ld_rdata = mem_rdata (pass-through), meaningful only when the matching rvalid is set.
- Read latency is exactly 1 cycle after grant. A write completes in its grant cycle with no response.
- Simultaneous cpu_req & ld_req in S_NORM: the CPU wins unless force is set. A forced loader grant lasts exactly one cycle, then the counter restarts.
- The CPU must hold its request and operands while cpu_stall = 1. The loader must hold its request and operands until ld_gnt = 1.
- Reset mid-lock or mid-read: state returns to S_NORM and pending rvalids are dropped (0 the cycle after reset).

Test Plan:
- Reset, then idle: mem_en = 0, cpu_stall = 0, both rvalids = 0, state S_NORM.
- CPU load alone, addr 0x10, RAM[0x10] = 0xDEADBEEF: mem_en = 1 and mem_addr = 0x10 in cycle 0; cpu_rvalid = 1 with cpu_rdata = 0xDEADBEEF in cycle 1; cpu_stall = 0 throughout.
- cpu_req and ld_req held high continuously, WAIT_MAX = 4: the CPU is granted 4 cycles, then in the 5th cycle ld_gnt = 1 with cpu_stall = 1. The pattern repeats with period 5.
- Loader lock: write 0x1234 to 0x40 with ld_lock = 1 for 3 cycles while cpu_req = 1: cpu_stall = 1 for all 3 cycles, ld_gnt = 1 each cycle. ld_lock drops in cycle 3; the CPU is granted in cycle 4.
- Loader read during lock, then rst asserted in the next cycle: ld_rvalid = 0 after reset, state S_NORM, the CPU is granted the cycle after rst deasserts.
- CPU store addr 0x20 data 0xA5A5A5A5 while the loader reads 0x20: the store is granted first, and the loader read returns 0xA5A5A5A5.
